// File: rtl/icache_pkg.sv
// Shared geometry, constants and FSM encoding for the direct-mapped instruction cache.
package icache_pkg;
  localparam int LINES  = 32;
  localparam int WORDS  = 4;
  localparam int TAG_W  = 23;
  localparam int IDX_W  = 5;
  localparam int WORD_W = 2;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2
  } state_t;
endpackage

// File: rtl/icache_array.sv
// Tag/valid/data storage: asynchronous read for zero-latency hits, one word write port, valid clear.
module icache_array
  import icache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [WORD_W-1:0] rd_word,
  output logic [TAG_W-1:0]  rd_tag,
  output logic              rd_valid,
  output logic [31:0]       rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [WORD_W-1:0] wr_word,
  input  logic [31:0]       wr_data,
  input  logic              tag_wr,
  input  logic [TAG_W-1:0]  wr_tag
);
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES*WORDS];
  logic [LINES-1:0] valid_reg;

  // Tag and data contents are deliberately left unreset; only valid bits carry meaning.
  always_ff @(posedge clk) begin
    if (wr_en)
      data_mem[{wr_idx, wr_word}] <= wr_data;
    if (tag_wr)
      tag_mem[wr_idx] <= wr_tag;
  end

  for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
    always_ff @(posedge clk) begin
      if (rst)
        valid_reg[gi] <= 1'b0;
      else if (tag_wr && (wr_idx == IDX_W'(gi)))
        valid_reg[gi] <= 1'b1;
    end
  end

  assign rd_tag   = tag_mem[rd_idx];
  assign rd_valid = valid_reg[rd_idx];
  assign rd_data  = data_mem[{rd_idx, rd_word}];
endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped I-cache controller: combinational hit path, single-request four-beat refill.
module icache_ctrl
  import icache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC,
  output logic [31:0] instr,
  output logic        stall,
  output logic        mem_rd_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rdata_valid
);
  state_t            state_reg, state_next;
  logic [WORD_W-1:0] cnt_reg;
  logic [31:0]       addr_reg;

  logic [TAG_W-1:0]  rd_tag;
  logic              rd_valid;
  logic [31:0]       rd_data;
  logic              hit;
  logic              wr_en;
  logic              tag_wr;
  logic              unused_pc_bits;

  assign unused_pc_bits = ^PC[1:0];

  icache_array u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (PC[8:4]),
    .rd_word  (PC[3:2]),
    .rd_tag   (rd_tag),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_idx   (addr_reg[8:4]),
    .wr_word  (cnt_reg),
    .wr_data  (mem_rdata),
    .tag_wr   (tag_wr),
    .wr_tag   (addr_reg[31:9])
  );

  assign hit = rd_valid && (rd_tag == PC[31:9]);

  // Refill writes are steered only by the latched address, never by the live PC.
  assign wr_en    = !rst && (state_reg == FILL) && mem_rdata_valid;
  assign tag_wr   = wr_en && (cnt_reg == WORD_W'(WORDS - 1));
  assign mem_addr = addr_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && !hit)
        addr_reg <= {PC[31:4], 4'b0000};
      if (state_reg == REQ)
        cnt_reg <= '0;
      else if (wr_en)
        cnt_reg <= cnt_reg + WORD_W'(1);
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (!hit) state_next = REQ;
      REQ:     state_next = FILL;
      FILL:    if (tag_wr) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    instr      = NOP_INSTR;
    stall      = 1'b0;
    mem_rd_req = 1'b0;
    if (!rst) begin
      case (state_reg)
        IDLE: begin
          if (hit) instr = rd_data;
          else     stall = 1'b1;
        end
        REQ: begin
          stall      = 1'b1;
          mem_rd_req = 1'b1;
        end
        default: stall = 1'b1;
      endcase
    end
  end
endmodule

// File: tb/tb_icache_ctrl.sv
// Scoreboard bench for icache_ctrl: fetch driver, memory responder and an output monitor.
module tb_icache_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] PC = 32'h0;
  logic [31:0] instr;
  logic        stall;
  logic        mem_rd_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_rdata_valid;

  int tests = 0;
  int fails = 0;

  logic [31:0] instr_q [$];
  logic [31:0] addr_q  [$];

  int beats_lim  = 4;
  int gap        = 0;
  int mem_done   = 0;
  int stray_req  = 0;
  int stray_done = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  icache_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .PC              (PC),
    .instr           (instr),
    .stall           (stall),
    .mem_rd_req      (mem_rd_req),
    .mem_addr        (mem_addr),
    .mem_rdata       (mem_rdata),
    .mem_rdata_valid (mem_rdata_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Backing store: block 0 holds the hand-chosen words, every other word is 0x1000_0000|addr.
  function automatic logic [31:0] backing(input logic [31:0] a);
    if (a[31:4] == 28'h0) begin
      case (a[3:2])
        2'd0:    backing = 32'h11;
        2'd1:    backing = 32'h22;
        2'd2:    backing = 32'h33;
        default: backing = 32'h44;
      endcase
    end else begin
      backing = 32'h1000_0000 | a;
    end
  endfunction

  // Monitor: pops expectations whenever the DUT presents a fetch result or a refill request.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_req", {31'b0, mem_rd_req}, 32'd0);
        check("rst_instr", instr, NOP);
      end else begin
        if (mem_rd_req) begin
          if (addr_q.size() == 0) begin
            check("unexpected_req", mem_addr, 32'hFFFF_FFFF);
          end else begin
            e = addr_q.pop_front();
            check("mem_addr", mem_addr, e);
          end
        end
        if (stall) begin
          check("stall_nop", instr, NOP);
        end else if (instr_q.size() > 0) begin
          e = instr_q.pop_front();
          check("instr", instr, e);
        end
      end
    end
  end

  // Memory responder: serves each request with in-order beats, optional gaps, and stray beats.
  initial begin
    logic [31:0] a;
    mem_rdata_valid = 1'b0;
    mem_rdata       = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_rd_req && !rst) begin
        a = mem_addr;
        for (int b = 0; b < beats_lim; b++) begin
          if (b > 0) begin
            repeat (gap) begin
              @(posedge clk); #1;
              mem_rdata_valid = 1'b0;
            end
          end
          @(posedge clk); #1;
          mem_rdata_valid = 1'b1;
          mem_rdata       = backing(a + 32'(4 * b));
        end
        @(posedge clk); #1;
        mem_rdata_valid = 1'b0;
        mem_done++;
      end else if (stray_done < stray_req) begin
        while (stray_done < stray_req) begin
          @(posedge clk); #1;
          mem_rdata_valid = 1'b1;
          mem_rdata       = 32'hDEAD_BEEF;
          stray_done++;
        end
        @(posedge clk); #1;
        mem_rdata_valid = 1'b0;
      end
    end
  end

  // Presents pc now and waits for the monitor to consume the expected word, counting stalls.
  task automatic fetch_go(input logic [31:0] pc, input logic [31:0] exp,
                          input int exp_stall, input bit miss);
    int cnt = 0;
    PC = pc;
    if (miss) addr_q.push_back({pc[31:4], 4'b0000});
    instr_q.push_back(exp);
    forever begin
      @(negedge clk); #1;
      if (instr_q.size() == 0) break;
      cnt++;
      if (cnt > 200) begin
        check("fetch_timeout", pc, 32'hFFFF_FFFF);
        instr_q.delete();
        break;
      end
    end
    check("stall_cycles", 32'(cnt), 32'(exp_stall));
    $display("[TB] fetch pc=%h instr=%h stalls=%0d", pc, exp, cnt);
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] exp,
                       input int exp_stall, input bit miss);
    @(posedge clk); #1;
    fetch_go(pc, exp, exp_stall, miss);
  endtask

  initial begin
    int d0;
    int waited;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    // Cold miss on block 0, then sequential hits in the same line.
    fetch_go(32'h0, 32'h11, 6, 1'b1);
    fetch(32'h4, 32'h22, 0, 1'b0);
    fetch(32'h8, 32'h33, 0, 1'b0);
    fetch(32'hC, 32'h44, 0, 1'b0);
    // Same index, new tag evicts block 0; unaligned PC still selects its word.
    fetch(32'h200, 32'h1000_0200, 6, 1'b1);
    fetch(32'h207, 32'h1000_0204, 0, 1'b0);
    fetch(32'h0, 32'h11, 6, 1'b1);
    // Highest index line.
    fetch(32'h1F0, 32'h1000_01F0, 6, 1'b1);
    fetch(32'h1FC, 32'h1000_01FC, 0, 1'b0);
    // Three idle cycles between beats.
    gap = 3;
    fetch(32'h400, 32'h1000_0400, 15, 1'b1);
    gap = 0;
    fetch(32'h408, 32'h1000_0408, 0, 1'b0);
    fetch(32'h40C, 32'h1000_040C, 0, 1'b0);
    // Reset after the second beat of a refill, with stray beats during reset.
    beats_lim = 2;
    d0 = mem_done;
    @(posedge clk); #1;
    PC = 32'h600;
    addr_q.push_back(32'h600);
    waited = 0;
    while (mem_done == d0 && waited < 50) begin
      @(negedge clk); #1;
      waited++;
    end
    check("abort_wait", 32'(mem_done - d0), 32'd1);
    beats_lim = 4;
    @(posedge clk); #1;
    rst = 1'b1;
    PC  = 32'h0;
    stray_req = stray_req + 2;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    $display("[TB] reset mid-refill applied");
    fetch_go(32'h0, 32'h11, 6, 1'b1);
    fetch(32'h600, 32'h1000_0600, 6, 1'b1);
    fetch(32'h0, 32'h11, 6, 1'b1);
    fetch(32'h4, 32'h22, 0, 1'b0);
    // Stray beats while hitting in IDLE must not touch the array.
    stray_req = stray_req + 2;
    repeat (4) fetch(32'h4, 32'h22, 0, 1'b0);
    fetch(32'h0, 32'h11, 0, 1'b0);
    fetch(32'hC, 32'h44, 0, 1'b0);
    repeat (3) @(posedge clk);
    check("addr_q_empty", 32'(addr_q.size()), 32'd0);
    check("instr_q_empty", 32'(instr_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
